// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: decode-side control, instruction memory port and the IF/ID outputs.
interface instr_fetch_if;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] instr_in;
   logic [31:0] pc_addr;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_valid;

   // Fetch unit side.
   modport master (
      input  stall,
      input  redirect,
      input  redirect_pc,
      input  instr_in,
      output pc_addr,
      output id_pc,
      output id_instr,
      output id_valid
   );

   // Pipeline / memory side.
   modport slave (
      output stall,
      output redirect,
      output redirect_pc,
      output instr_in,
      input  pc_addr,
      input  id_pc,
      input  id_instr,
      input  id_valid
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage with a one-entry skid buffer.
// The instruction memory returns data one cycle after the address, so a stall
// catches the in-flight word in the buffer (HOLD) and replays it on release.
module instr_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input logic          clk,
   input logic          rst,
   instr_fetch_if.master bus
);

   typedef enum logic {StRun, StHold} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q;
   logic [31:0] req_pc_q;
   logic        req_valid_q;
   logic [31:0] buf_pc_q;
   logic [31:0] buf_instr_q;
   logic [31:0] id_pc_q;
   logic [31:0] id_instr_q;
   logic        id_valid_q;

   logic        load_buf;
   logic        from_buf;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: redirect always returns to RUN, a stall with data in flight enters HOLD.
   always_comb begin
      state_d = state_q;
      if (bus.redirect) begin
         state_d = StRun;
      end else if (bus.stall) begin
         if (state_q == StRun && req_valid_q) begin
            state_d = StHold;
         end
      end else begin
         state_d = StRun;
      end
   end

   // FSM outputs: when to capture the in-flight word and when to replay it.
   always_comb begin
      load_buf = 1'b0;
      from_buf = 1'b0;
      unique case (state_q)
         StRun:   load_buf = !bus.redirect && bus.stall && req_valid_q;
         StHold:  from_buf = !bus.redirect && !bus.stall;
         default: ;
      endcase
   end

   // Datapath: fetch address, request tracking, skid buffer and IF/ID register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         req_pc_q    <= '0;
         req_valid_q <= 1'b0;
         buf_pc_q    <= '0;
         buf_instr_q <= '0;
         id_pc_q     <= '0;
         id_instr_q  <= NOP_INSTR;
         id_valid_q  <= 1'b0;
      end else if (bus.redirect) begin
         // id_pc is left as-is; id_valid=0 marks it meaningless.
         pc_q        <= {bus.redirect_pc[31:2], 2'b00};
         req_valid_q <= 1'b0;
         id_valid_q  <= 1'b0;
         id_instr_q  <= NOP_INSTR;
      end else if (bus.stall) begin
         if (load_buf) begin
            buf_instr_q <= bus.instr_in;
            buf_pc_q    <= req_pc_q;
         end
      end else begin
         if (from_buf) begin
            id_instr_q <= buf_instr_q;
            id_pc_q    <= buf_pc_q;
            id_valid_q <= 1'b1;
         end else begin
            id_instr_q <= req_valid_q ? bus.instr_in : NOP_INSTR;
            id_pc_q    <= req_pc_q;
            id_valid_q <= req_valid_q;
         end
         req_pc_q    <= pc_q;
         req_valid_q <= 1'b1;
         // Wraps modulo 2^32.
         pc_q        <= pc_q + 32'd4;
      end
   end

   assign bus.pc_addr  = pc_q;
   assign bus.id_pc    = id_pc_q;
   assign bus.id_instr = id_instr_q;
   assign bus.id_valid = id_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table plus a stall-pattern stream check.
module tb_instr_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk;
   logic rst;
   instr_fetch_if bus ();

   instr_fetch #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (NOP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents model.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0000) return 32'h0050_0093;
      if (a == 32'h0000_0004) return 32'h0010_8113;
      return a ^ 32'h5A00_0003;
   endfunction

   // Registered instruction memory: data for the address seen at the previous edge.
   always @(posedge clk) bus.instr_in <= mem_word(bus.pc_addr);

   typedef struct {
      logic        rst;
      logic        stall;
      logic        redirect;
      logic [31:0] rpc;
      logic [31:0] e_pc;
      logic        e_v;
      logic [31:0] e_idpc;
      logic [31:0] e_instr;
   } vec_t;

   vec_t vecs[32];
   int   checks;
   int   errors;

   function automatic vec_t mk(input logic r, input logic s, input logic rd,
                               input logic [31:0] rp, input logic [31:0] pc,
                               input logic v, input logic [31:0] idpc);
      vec_t t;
      t.rst      = r;
      t.stall    = s;
      t.redirect = rd;
      t.rpc      = rp;
      t.e_pc     = pc;
      t.e_v      = v;
      t.e_idpc   = idpc;
      t.e_instr  = v ? mem_word(idpc) : NOP;
      return t;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive inputs on the falling edge, then sample just after the rising edge.
   task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rp);
      @(negedge clk);
      rst             = r;
      bus.stall       = s;
      bus.redirect    = rd;
      bus.redirect_pc = rp;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] exp_pc;
      int          n_adv;
      int          n_val;
      logic        s;

      checks = 0;
      errors = 0;
      rst             = 1'b1;
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;

      //            rst stall redir rpc            pc_addr        v     id_pc
      vecs[0]  = mk(1, 0, 0, 32'h0,         32'h0,         0, 32'h0);
      vecs[1]  = mk(1, 0, 0, 32'h0,         32'h0,         0, 32'h0);
      vecs[2]  = mk(0, 0, 0, 32'h0,         32'h4,         0, 32'h0);
      vecs[3]  = mk(0, 0, 0, 32'h0,         32'h8,         1, 32'h0);
      vecs[4]  = mk(0, 0, 0, 32'h0,         32'hC,         1, 32'h4);
      vecs[5]  = mk(0, 1, 0, 32'h0,         32'hC,         1, 32'h4);
      vecs[6]  = mk(0, 1, 0, 32'h0,         32'hC,         1, 32'h4);
      vecs[7]  = mk(0, 1, 0, 32'h0,         32'hC,         1, 32'h4);
      vecs[8]  = mk(0, 0, 0, 32'h0,         32'h10,        1, 32'h8);
      vecs[9]  = mk(0, 0, 0, 32'h0,         32'h14,        1, 32'hC);
      vecs[10] = mk(0, 0, 0, 32'h0,         32'h18,        1, 32'h10);
      vecs[11] = mk(0, 0, 1, 32'h103,       32'h100,       0, 32'h10);
      vecs[12] = mk(0, 0, 0, 32'h0,         32'h104,       0, 32'h14);
      vecs[13] = mk(0, 0, 0, 32'h0,         32'h108,       1, 32'h100);
      vecs[14] = mk(0, 1, 0, 32'h0,         32'h108,       1, 32'h100);
      vecs[15] = mk(0, 1, 1, 32'h200,       32'h200,       0, 32'h100);
      vecs[16] = mk(0, 0, 0, 32'h0,         32'h204,       0, 32'h104);
      vecs[17] = mk(0, 0, 0, 32'h0,         32'h208,       1, 32'h200);
      vecs[18] = mk(0, 0, 1, 32'hFFFF_FFF9, 32'hFFFF_FFF8, 0, 32'h200);
      vecs[19] = mk(0, 0, 0, 32'h0,         32'hFFFF_FFFC, 0, 32'h204);
      vecs[20] = mk(0, 0, 0, 32'h0,         32'h0,         1, 32'hFFFF_FFF8);
      vecs[21] = mk(0, 0, 0, 32'h0,         32'h4,         1, 32'hFFFF_FFFC);
      vecs[22] = mk(0, 0, 0, 32'h0,         32'h8,         1, 32'h0);
      vecs[23] = mk(0, 0, 1, 32'h40,        32'h40,        0, 32'h0);
      vecs[24] = mk(0, 0, 1, 32'h80,        32'h80,        0, 32'h0);
      vecs[25] = mk(0, 0, 0, 32'h0,         32'h84,        0, 32'h4);
      vecs[26] = mk(0, 0, 0, 32'h0,         32'h88,        1, 32'h80);
      vecs[27] = mk(0, 1, 0, 32'h0,         32'h88,        1, 32'h80);
      vecs[28] = mk(1, 1, 1, 32'h300,       32'h0,         0, 32'h0);
      vecs[29] = mk(0, 0, 0, 32'h0,         32'h4,         0, 32'h0);
      vecs[30] = mk(0, 0, 0, 32'h0,         32'h8,         1, 32'h0);
      vecs[31] = mk(0, 0, 0, 32'h0,         32'hC,         1, 32'h4);

      for (int i = 0; i < 32; i++) begin
         step(vecs[i].rst, vecs[i].stall, vecs[i].redirect, vecs[i].rpc);
         check32($sformatf("v%0d pc_addr", i), bus.pc_addr, vecs[i].e_pc);
         check32($sformatf("v%0d id_valid", i), {31'd0, bus.id_valid}, {31'd0, vecs[i].e_v});
         check32($sformatf("v%0d id_pc", i), bus.id_pc, vecs[i].e_idpc);
         check32($sformatf("v%0d id_instr", i), bus.id_instr, vecs[i].e_instr);
      end

      // Stall right after reset with nothing in flight: everything holds.
      step(1, 0, 0, 32'h0);
      step(0, 1, 0, 32'h0);
      check32("early_stall pc_addr", bus.pc_addr, 32'h0);
      check32("early_stall id_valid", {31'd0, bus.id_valid}, 32'd0);

      // Mixed stall lengths: every instruction exactly once, strictly +4.
      exp_pc = 32'h0;
      n_adv  = 0;
      n_val  = 0;
      for (int i = 0; i < 60; i++) begin
         s = ((i % 9) >= 5) || ((i % 13) == 2);
         step(0, s, 0, 32'h0);
         if (!s) begin
            n_adv++;
            if (bus.id_valid) begin
               check32($sformatf("stream%0d id_pc", i), bus.id_pc, exp_pc);
               check32($sformatf("stream%0d id_instr", i), bus.id_instr, mem_word(exp_pc));
               exp_pc = exp_pc + 32'd4;
               n_val++;
            end
         end else if (n_val > 0) begin
            check32($sformatf("stream%0d hold id_pc", i), bus.id_pc, exp_pc - 32'd4);
            check32($sformatf("stream%0d hold id_valid", i), {31'd0, bus.id_valid}, 32'd1);
         end
      end
      check32("stream valid count", n_val, n_adv - 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), is the instruction driven on id_instr when id_valid=0.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  decode cannot accept; hold the fetch stream.
REQ-006 redirect  input  1  branch/jump taken; restart fetch at redirect_pc.
REQ-007 redirect_pc  input  32  new fetch address; bits [1:0] ignored and treated as 00.
REQ-008 instr_in  input  32  instr_mem read data, registered, equal to mem[pc_addr sampled at the previous rising edge].
REQ-009 pc_addr  output  32  fetch address driven to instr_mem.
REQ-010 id_pc  output  32  address of the instruction in id_instr.
REQ-011 id_instr  output  32  fetched instruction to decode (IF/ID register).
REQ-012 id_valid  output  1  id_instr/id_pc hold a real instruction.

Function
REQ-013 Internal state SHALL be: pc_addr, req_pc/req_valid (address issued last cycle, data arriving now), buf_pc/buf_instr, FSM {RUN, HOLD}, and the id_* registers.
REQ-014 Priority each cycle SHALL be rst > redirect > stall > advance.
REQ-015 Redirect (any state): pc_addr<=redirect_pc with [1:0]=00; req_valid<=0; FSM<=RUN; id_valid<=0; id_instr<=NOP_INSTR; id_pc unchanged; buffer discarded.
REQ-016 Stall in RUN with req_valid=1: buf_instr<=instr_in, buf_pc<=req_pc, FSM<=HOLD; pc_addr and id_* hold.
REQ-017 Stall in RUN with req_valid=0: all state holds; FSM stays RUN.
REQ-018 Stall in HOLD: all state holds; buffer keeps its contents.
REQ-019 Advance in RUN: id_instr<=req_valid?instr_in:NOP_INSTR; id_pc<=req_pc; id_valid<=req_valid; req_pc<=pc_addr; req_valid<=1; pc_addr<=pc_addr+4.
REQ-020 Advance in HOLD: id_instr<=buf_instr; id_pc<=buf_pc; id_valid<=1; req_pc<=pc_addr; req_valid<=1; pc_addr<=pc_addr+4; FSM<=RUN.
REQ-021 pc_addr+4 SHALL be modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-022 Latency: instruction at address A fetched with no stall/redirect appears on id_* exactly 2 cycles after pc_addr=A.
REQ-023 No instruction SHALL be lost or duplicated across any stall length (1..N cycles); id_pc sequence SHALL be strictly +4 between redirects.
REQ-024 Redirect asserted together with stall SHALL be taken; redirect in the release cycle of HOLD discards buf_instr.
REQ-025 Continuous redirect SHALL keep id_valid=0 and reload pc_addr every cycle.

Reset
REQ-026 While rst=1 at a rising edge: pc_addr<=RESET_PC, req_pc<=0, req_valid<=0, buf_pc<=0, buf_instr<=0, FSM<=RUN, id_pc<=0, id_instr<=NOP_INSTR, id_valid<=0.
REQ-027 Reset mid-operation (any state, any stall/redirect value) SHALL override all other inputs in that cycle.
REQ-028 First id_valid=1 SHALL occur 2 cycles after the first edge with rst=0, with id_pc=RESET_PC.

Verification
REQ-029 Reset release, stall=0, mem[0]=32'h0050_0093, mem[4]=32'h0010_8113 -> pc_addr 0,4,8,...; id_valid=1 from cycle 2 with (id_pc,id_instr)=(0,00500093) then (4,00108113).
REQ-030 Stall high 3 cycles starting while id_pc=4 -> id_* frozen at 4 for 3 cycles, then id_pc 8,C,10 with correct mem contents, no gap or repeat.
REQ-031 Redirect to 32'h0000_0103 while streaming -> next cycle pc_addr=0x100, id_valid=0 for 2 cycles, then id_pc=0x100, id_instr=mem[0x100].
REQ-032 Redirect and stall asserted together while in HOLD -> redirect taken, buffered instruction never appears, next valid id_pc=redirect target.
REQ-033 Redirect to 32'hFFFF_FFF8 -> id_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-034 rst asserted for 1 cycle while in HOLD -> pc_addr=RESET_PC, id_valid=0, id_instr=NOP_INSTR next cycle; stream restarts per REQ-028.
